// File: rtl/s2p_stream_conv_if.sv
// Bundle of the serial input, parallel output handshake and status signals of s2p_stream_conv.
// S2P_PARITY_EN widens bit_cnt so it can count the trailing parity bit.
interface s2p_stream_conv_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FCNT_W = 8
);
`ifdef S2P_PARITY_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);
`else
  localparam int unsigned CntW = $clog2(WIDTH);
`endif
  localparam int unsigned LenW = $clog2(WIDTH) + 1;

  logic              din;
  logic              din_vld;
  logic              sof;
  logic              msb_first;
  logic              conp;
  logic [WIDTH-1:0]  pout;
  logic [LenW-1:0]   pout_len;
  logic              pout_vld;
  logic              pout_rdy;
  logic              pout_perr;
  logic [CntW-1:0]   bit_cnt;
  logic              ovr;
  logic              clr_ovr;
  logic [FCNT_W-1:0] word_cnt;

  modport master (
    output din, din_vld, sof, msb_first, conp, pout_rdy, clr_ovr,
    input  pout, pout_len, pout_vld, pout_perr, bit_cnt, ovr, word_cnt
  );

  modport slave (
    input  din, din_vld, sof, msb_first, conp, pout_rdy, clr_ovr,
    output pout, pout_len, pout_vld, pout_perr, bit_cnt, ovr, word_cnt
  );
endinterface

// File: rtl/s2p_stream_conv.sv
// Serial-to-parallel converter: MSB/LSB-first assembly, flush, sof resync, one-word output buffer.
// Define S2P_PARITY_EN to consume a trailing even-parity bit per word and report pout_perr.
module s2p_stream_conv #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   clrs,
  s2p_stream_conv_if.slave       bus
);
`ifdef S2P_PARITY_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  // Word completes on the parity bit that follows the WIDTH data bits.
  localparam logic [CntW-1:0] DoneCnt = CntW'(WIDTH);
`else
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] DoneCnt = CntW'(WIDTH - 1);
`endif
  localparam int unsigned LenW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              msb_q, msb_d;
  logic [WIDTH-1:0]  hold_q;
  logic [LenW-1:0]   len_q;
  logic              vld_q;
  logic              ovr_q;
  logic [FCNT_W-1:0] wcnt_q;
`ifdef S2P_PARITY_EN
  logic              perr_q;
  logic              ld_perr;
`endif

  logic              ord;
  logic [WIDTH-1:0]  shifted;
  logic              ld;
  logic [WIDTH-1:0]  ld_word;
  logic [LenW-1:0]   ld_len;
  logic [LenW-1:0]   fl_n;
  logic [LenW-1:0]   fl_sh;
  logic [WIDTH-1:0]  fl_data;
  logic              fl_ord;
  logic              blocked;
  logic              xfer;

  always_comb begin
    // A new word (first bit or sof restart) takes the live msb_first; otherwise the latched one.
    ord     = (bus.sof || cnt_q == '0) ? bus.msb_first : msb_q;
    shifted = ord ? {sreg_q[WIDTH-2:0], bus.din} : {bus.din, sreg_q[WIDTH-1:1]};

    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    ld      = 1'b0;
    ld_word = '0;
    ld_len  = '0;
    fl_n    = '0;
    fl_data = sreg_q;
    fl_ord  = msb_q;
`ifdef S2P_PARITY_EN
    ld_perr = 1'b0;
`endif

    if (bus.sof) begin
      // Flush sees only the bits held before this edge; a bit on this edge starts the new word.
      if (bus.conp && cnt_q != '0) begin
        fl_n = LenW'(cnt_q);
      end
      if (bus.din_vld) begin
        sreg_d = shifted;
        cnt_d  = CntW'(1);
        msb_d  = bus.msb_first;
      end else begin
        cnt_d  = '0;
      end
    end else if (bus.din_vld) begin
      msb_d = ord;
      if (cnt_q == DoneCnt) begin
        ld     = 1'b1;
        ld_len = LenW'(WIDTH);
        cnt_d  = '0;
`ifdef S2P_PARITY_EN
        ld_word = sreg_q;
        ld_perr = (^sreg_q) ^ bus.din;
`else
        ld_word = shifted;
        sreg_d  = shifted;
`endif
      end else begin
        sreg_d = shifted;
        if (bus.conp) begin
          fl_n    = LenW'(cnt_q) + LenW'(1);
          fl_data = shifted;
          fl_ord  = ord;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
      end
    end else if (bus.conp && cnt_q != '0) begin
      fl_n  = LenW'(cnt_q);
      cnt_d = '0;
    end

    // Shifting out the stale bits left over from the previous word yields the zero padding.
    fl_sh = LenW'(WIDTH) - fl_n;
    if (fl_n != '0) begin
      ld      = 1'b1;
      ld_len  = fl_n;
      ld_word = fl_ord ? (fl_data << fl_sh) : (fl_data >> fl_sh);
    end
  end

  assign blocked = vld_q && !bus.pout_rdy;
  assign xfer    = vld_q && bus.pout_rdy;

  always_ff @(posedge clk) begin
    if (!clrs) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      msb_q  <= 1'b0;
      hold_q <= '0;
      len_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      wcnt_q <= '0;
`ifdef S2P_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      msb_q  <= msb_d;
      if (ld && !blocked) begin
        hold_q <= ld_word;
        len_q  <= ld_len;
        vld_q  <= 1'b1;
        wcnt_q <= wcnt_q + FCNT_W'(1);
`ifdef S2P_PARITY_EN
        perr_q <= ld_perr;
`endif
      end else if (xfer) begin
        vld_q  <= 1'b0;
      end
      if (ld && blocked) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.pout     = hold_q;
  assign bus.pout_len = len_q;
  assign bus.pout_vld = vld_q;
  assign bus.bit_cnt  = cnt_q;
  assign bus.ovr      = ovr_q;
  assign bus.word_cnt = wcnt_q;
`ifdef S2P_PARITY_EN
  assign bus.pout_perr = perr_q;
`else
  assign bus.pout_perr = 1'b0;
`endif
endmodule

// File: tb/tb_s2p_stream_conv.sv
// Randomised and directed bench for s2p_stream_conv against a bit-queue reference model.
// Parity checks are built only when S2P_PARITY_EN is defined.
module tb_s2p_stream_conv;
  localparam int unsigned W  = 16;
  localparam int unsigned FW = 8;
`ifdef S2P_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrs;
  always #5 clk = ~clk;

  s2p_stream_conv_if #(.WIDTH(W), .FCNT_W(FW)) bus ();
  s2p_stream_conv #(.WIDTH(W), .FCNT_W(FW)) dut (.clk(clk), .clrs(clrs), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: bits of the current partial word kept in arrival order.
  bit              q_bits[$];
  bit              m_ord;
  logic [W-1:0]    m_pout;
  int unsigned     m_len;
  bit              m_vld, m_perr, m_ovr;
  logic [FW-1:0]   m_wcnt;

  function automatic logic [W-1:0] pack_bits(input bit ord);
    logic [W-1:0] w = '0;
    for (int i = 0; i < q_bits.size(); i++) begin
      if (ord) w[W-1-i] = q_bits[i];
      else     w[i]     = q_bits[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    bit           ld = 1'b0;
    logic [W-1:0] lw = '0;
    int unsigned  ll = 0;
    bit           lp = 1'b0;
    bit           blocked;
    if (!clrs) begin
      q_bits.delete();
      m_ord = 0; m_pout = '0; m_len = 0; m_vld = 0; m_perr = 0; m_ovr = 0; m_wcnt = '0;
      return;
    end
    blocked = m_vld && !bus.pout_rdy;
    if (bus.sof) begin
      if (bus.conp && q_bits.size() > 0) begin
        ld = 1; lw = pack_bits(m_ord); ll = q_bits.size();
      end
      q_bits.delete();
      if (bus.din_vld) begin
        m_ord = bus.msb_first;
        q_bits.push_back(bus.din);
      end
    end else if (bus.din_vld) begin
      if (q_bits.size() == 0) m_ord = bus.msb_first;
      if (Par && q_bits.size() == W) begin
        ld = 1; lw = pack_bits(m_ord); ll = W; lp = (^lw) ^ bus.din;
        q_bits.delete();
      end else begin
        q_bits.push_back(bus.din);
        if ((!Par && q_bits.size() == W) || bus.conp) begin
          ld = 1; lw = pack_bits(m_ord); ll = q_bits.size();
          q_bits.delete();
        end
      end
    end else if (bus.conp && q_bits.size() > 0) begin
      ld = 1; lw = pack_bits(m_ord); ll = q_bits.size();
      q_bits.delete();
    end
    if (ld && blocked) m_ovr = 1;
    else if (bus.clr_ovr) m_ovr = 0;
    if (ld && !blocked) begin
      m_pout = lw; m_len = ll; m_perr = lp; m_vld = 1; m_wcnt++;
    end else if (m_vld && bus.pout_rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all();
    check("pout_vld",  bus.pout_vld,  m_vld);
    check("pout",      bus.pout,      m_pout);
    check("pout_len",  bus.pout_len,  m_len);
    check("pout_perr", bus.pout_perr, m_perr);
    check("bit_cnt",   bus.bit_cnt,   q_bits.size());
    check("ovr",       bus.ovr,       m_ovr);
    check("word_cnt",  bus.word_cnt,  m_wcnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_bit(input bit b);
    bus.din = b; bus.din_vld = 1'b1;
    cyc();
    bus.din_vld = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit msb);
    bus.msb_first = msb;
    for (int i = 0; i < W; i++) send_bit(msb ? v[W-1-i] : v[i]);
`ifdef S2P_PARITY_EN
    send_bit(^v);
`endif
  endtask

  task automatic do_reset();
    clrs = 1'b0;
    cyc();
    cyc();
    clrs = 1'b1;
  endtask

  initial begin
    logic [W-1:0] v;
    clrs = 1'b0;
    bus.din = 0; bus.din_vld = 0; bus.sof = 0; bus.msb_first = 1; bus.conp = 0;
    bus.pout_rdy = 1; bus.clr_ovr = 0;
    do_reset();
    check("rst_pout", bus.pout, 0);
    check("rst_wcnt", bus.word_cnt, 0);

    // MSB-first full word
    send_word(16'hA5C3, 1'b1);
    check("t1_pout", bus.pout, 16'hA5C3);
    check("t1_vld",  bus.pout_vld, 1);
    check("t1_len",  bus.pout_len, 16);
    check("t1_wcnt", bus.word_cnt, 1);
    cyc();

    // LSB-first, then msb_first toggled after the first bit
    send_word(16'h1234, 1'b0);
    check("t2_pout", bus.pout, 16'h1234);
    cyc();
    v = 16'h1234;
    for (int i = 0; i < W; i++) begin
      bus.msb_first = (i != 0);
      send_bit(v[i]);
    end
`ifdef S2P_PARITY_EN
    send_bit(^v);
`endif
    check("t2_toggle", bus.pout, 16'h1234);

    // Partial flush, both orders
    for (int k = 0; k < 2; k++) begin
      bus.msb_first = (k == 0);
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      bus.conp = 1; cyc(); bus.conp = 0;
      check("t3_pout", bus.pout, (k == 0) ? 16'hB000 : 16'h000D);
      check("t3_len",  bus.pout_len, 4);
      cyc();
    end

    // Overrun with a stalled consumer
    do_reset();
    bus.pout_rdy = 0;
    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b1);
    check("t4_pout", bus.pout, 16'h1111);
    check("t4_ovr",  bus.ovr, 1);
    check("t4_wcnt", bus.word_cnt, 1);
    bus.pout_rdy = 1; cyc();
    check("t4_drain", bus.pout_vld, 0);
    bus.clr_ovr = 1; cyc(); bus.clr_ovr = 0;
    check("t4_clr", bus.ovr, 0);

    // sof resync discards the partial word
    do_reset();
    bus.msb_first = 1;
    for (int i = 0; i < 7; i++) send_bit(1);
    bus.sof = 1; send_bit(1); bus.sof = 0;
    check("t5_cnt", bus.bit_cnt, 1);
    v = 16'h8ABC;
    for (int i = 1; i < W; i++) send_bit(v[W-1-i]);
`ifdef S2P_PARITY_EN
    send_bit(^v);
`endif
    check("t5_pout", bus.pout, 16'h8ABC);
    check("t5_wcnt", bus.word_cnt, 1);
    for (int i = 0; i < 5; i++) send_bit(1);
    bus.din_vld = 1; clrs = 0; cyc(); bus.din_vld = 0; clrs = 1;
    check("t5_rst_vld",  bus.pout_vld, 0);
    check("t5_rst_cnt",  bus.bit_cnt, 0);
    check("t5_rst_wcnt", bus.word_cnt, 0);
    check("t5_rst_pout", bus.pout, 0);

`ifdef S2P_PARITY_EN
    // Parity good then bad
    bus.msb_first = 1; v = 16'h0001;
    for (int i = 0; i < W; i++) send_bit(v[W-1-i]);
    send_bit(1);
    check("t6_perr_ok", bus.pout_perr, 0);
    for (int i = 0; i < W; i++) send_bit(v[W-1-i]);
    send_bit(0);
    check("t6_perr_bad", bus.pout_perr, 1);
`endif

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      clrs          = $urandom_range(0, 299) != 0;
      bus.din       = $urandom_range(0, 1) == 1;
      bus.din_vld   = $urandom_range(0, 9) < 7;
      bus.sof       = $urandom_range(0, 39) == 0;
      bus.conp      = $urandom_range(0, 19) == 0;
      bus.pout_rdy  = $urandom_range(0, 9) < 6;
      bus.clr_ovr   = $urandom_range(0, 24) == 0;
      if ($urandom_range(0, 9) == 0) bus.msb_first = ~bus.msb_first;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/s2p_stream_conv.md
Name: s2p_stream_conv

Overview:
- Parametrised serial-to-parallel converter; successor to the fixed 16-bit converter.
- Assembles WIDTH-bit words from a qualified serial bit stream, with MSB-first or LSB-first ordering.
- Presents each word on a valid/ready output with a one-word holding register, supports forced flush of partial words (conp), and reports overrun.
- Sits between a serial front end and any parallel consumer in the datapath.

Parameters:
- WIDTH, 16, bits per parallel word (2..64).
- FCNT_W, 8, width of completed-word counter (wraps).

Ports:
- clk  in  1  clock, rising edge.
- clrs  in  1  synchronous active-low reset.
- din  in  1  serial data bit.
- din_vld  in  1  din is sampled only when 1.
- sof  in  1  start-of-frame resync; discards any partial word.
- msb_first  in  1  1 = first received bit lands at pout[WIDTH-1]; 0 = first bit lands at pout[0].
- conp  in  1  flush request; emits the partial word.
- pout  out  WIDTH  parallel word.
- pout_len  out  $clog2(WIDTH)+1  number of valid bits in pout (WIDTH for full words).
- pout_vld  out  1  word available.
- pout_rdy  in  1  consumer accepts the word.
- pout_perr  out  1  parity error for the word on pout (see Optional Feature).
- bit_cnt  out  $clog2(WIDTH)  bits accumulated in the current partial word.
- ovr  out  1  sticky overrun flag.
- clr_ovr  in  1  clears ovr.
- word_cnt  out  FCNT_W  count of words handed to the holding register; wraps at 2^FCNT_W.

Behaviour:
Reset:
- Reset is synchronous and active-low. With clrs=0 at a rising edge, every register goes to 0.
- Outputs after reset: pout, pout_len, pout_vld, pout_perr, bit_cnt, ovr and word_cnt all 0. Shift register is 0.
- Reset mid-word or while pout_vld=1 drops all data; no word is emitted.

Bit ordering:
- msb_first is latched when a bit is accepted with bit_cnt==0. Changes mid-word are ignored until the next word.

Shifting:
- On din_vld=1, din is shifted in and bit_cnt increments.
- MSB-first: sreg <= {sreg[W-2:0], din}.
- LSB-first: sreg <= {din, sreg[W-1:1]}.

Word completion:
- When din_vld=1 and bit_cnt==WIDTH-1, the word is complete.
- On that same edge: the assembled word goes into the holding register, pout_vld=1, pout_len=WIDTH, bit_cnt=0, and word_cnt increments.
- Latency: the word is visible in the cycle after the edge that samples the last bit.

Output handshake:
- Transfer occurs when pout_vld && pout_rdy. pout_vld then drops unless a new word loads on the same edge.
- pout and pout_len are held stable while pout_vld && !pout_rdy.
- Completion and transfer on the same edge: the new word loads and pout_vld stays 1.

Overrun:
- A word completes or is flushed while pout_vld && !pout_rdy: the new word is dropped, the holding register is unchanged, ovr is set, word_cnt does not increment, and bit_cnt still returns to 0.
- clr_ovr clears ovr. If clr_ovr and a new overrun occur on the same edge, set wins.

Flush (conp=1):
- Applies only when the effective count is >0. The effective count includes a bit accepted on the same edge.
- The partial word is emitted zero-padded. MSB-first: received bits occupy the top positions. LSB-first: received bits occupy the low positions.
- pout_len = count; bit_cnt becomes 0.
- conp with count 0: no effect.
- conp on the edge where a word completes: a normal full word is emitted, with no extra empty word.

sof:
- sof=1 discards the partial word.
- sof with din_vld=1: that bit becomes bit 0 of the new word (bit_cnt=1), using the current msb_first.
- sof without din_vld: bit_cnt=0.
- sof and conp on the same edge: flush takes precedence over discard, and the flushed word excludes any bit accepted on that edge. If that edge also has din_vld, the bit starts the new word (bit_cnt=1).

Priority: clrs > sof/conp > shift.

Optional Feature:
- Macro: S2P_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra din_vld bit is consumed as an even-parity bit; the word completes on the parity bit.
  - pout_perr is registered with the word: 1 if XOR(data, parity)=1.
  - A flushed partial word has pout_perr=0.
  - bit_cnt counts to WIDTH, so its width becomes $clog2(WIDTH+1).
- Undefined: no parity bit is expected and pout_perr is tied to 0.

Test Plan:
1. WIDTH=16, reset, msb_first=1, pout_rdy=1, stream 0xA5C3 MSB-first -> one cycle after the 16th bit, pout=0xA5C3, pout_vld=1, pout_len=16, word_cnt=1.
2. msb_first=0, stream bits of 0x1234 starting from bit 0 -> pout=0x1234. Toggling msb_first mid-word -> still 0x1234.
3. msb_first=1, send 1,0,1,1 then conp -> pout=0xB000, pout_len=4. Repeat with msb_first=0 -> pout=0x000D.
4. pout_rdy=0, send two full words 0x1111 then 0x2222 -> pout holds 0x1111, ovr=1, word_cnt=1. Raise pout_rdy -> 0x1111 accepted, pout_vld=0. Pulse clr_ovr -> ovr=0.
5. Send 7 bits, then sof with din_vld (din=1), then 15 more bits -> the first 7 bits are absent and word_cnt increments once. Then clrs=0 mid-word -> all outputs 0, no word emitted.
6. With S2P_PARITY_EN defined: 0x0001 followed by parity bit 1 -> pout_perr=0. Same word followed by parity bit 0 -> pout_perr=1.
